// File: rtl/parameterized_univ_reg.sv
// Clocked w-bit universal register: sync set/clear, gate, load/shift/rotate/invert/increment,
// change-detect and saturating load count. Define UNIV_REG_PARITY_EN to add registered parity output par.
module parameterized_univ_reg #(
  parameter int w  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclr,
  input  logic          sset,
  input  logic          gate,
  input  logic [2:0]    mode,
  input  logic          sin,
  input  logic [w-1:0]  d,
  output logic [w-1:0]  q,
  output logic          sout,
  output logic          chg,
`ifdef UNIV_REG_PARITY_EN
  output logic          par,
`endif
  output logic [CW-1:0] lcnt
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'd0,
    MODE_LOAD = 3'd1,
    MODE_SHL  = 3'd2,
    MODE_SHR  = 3'd3,
    MODE_ROL  = 3'd4,
    MODE_ROR  = 3'd5,
    MODE_INV  = 3'd6,
    MODE_INC  = 3'd7
  } mode_e;

  mode_e         mode_sel;
  logic [w-1:0]  q_q, q_d;
  logic          sout_q, sout_d;
  logic          chg_q, chg_d;
  logic [CW-1:0] lcnt_q, lcnt_d;

  assign mode_sel = mode_e'(mode);

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    lcnt_d = lcnt_q;
    if (sclr) begin
      q_d    = '0;
      lcnt_d = '0;
    end else if (sset) begin
      q_d = '1;
    end else if (gate) begin
      case (mode_sel)
        MODE_HOLD: q_d = q_q;
        MODE_LOAD: begin
          q_d = d;
          // Saturate rather than wrap so a full count stays pinned at all ones.
          if (lcnt_q != '1) lcnt_d = lcnt_q + 1'b1;
        end
        MODE_SHL: begin
          q_d    = {q_q[w-2:0], sin};
          sout_d = q_q[w-1];
        end
        MODE_SHR: begin
          q_d    = {sin, q_q[w-1:1]};
          sout_d = q_q[0];
        end
        MODE_ROL:  q_d = {q_q[w-2:0], q_q[w-1]};
        MODE_ROR:  q_d = {q_q[0], q_q[w-1:1]};
        MODE_INV:  q_d = ~q_q;
        MODE_INC:  q_d = q_q + 1'b1;
        default:   q_d = q_q;
      endcase
    end
    chg_d = (q_d != q_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      chg_q  <= 1'b0;
      lcnt_q <= '0;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      chg_q  <= chg_d;
      lcnt_q <= lcnt_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign chg  = chg_q;
  assign lcnt = lcnt_q;

`ifdef UNIV_REG_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^q_d;
  end

  assign par = par_q;
`endif

endmodule

// File: tb/tb_parameterized_univ_reg.sv
// Self-checking bench for parameterized_univ_reg (w=4, CW=2) against an arithmetic reference model.
module tb_parameterized_univ_reg;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n, sclr, sset, gate, sin;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          sout, chg;
  logic [CW-1:0] lcnt;
`ifdef UNIV_REG_PARITY_EN
  logic          par;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_q = 0, m_sout = 0, m_chg = 0, m_lcnt = 0;

  parameterized_univ_reg #(.w(W), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sclr (sclr),
    .sset (sset),
    .gate (gate),
    .mode (mode),
    .sin  (sin),
    .d    (d),
    .q    (q),
    .sout (sout),
    .chg  (chg),
`ifdef UNIV_REG_PARITY_EN
    .par  (par),
`endif
    .lcnt (lcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int parity(input int v);
    int p = 0;
    for (int i = 0; i < W; i++) p ^= (v >> i) & 1;
    return p;
  endfunction

  task automatic model_edge();
    int mod = 1 << W;
    int lmax = (1 << CW) - 1;
    int nq;
    if (!rst_n) begin
      m_q = 0; m_sout = 0; m_chg = 0; m_lcnt = 0;
      return;
    end
    nq = m_q;
    if (sclr) begin
      nq = 0; m_lcnt = 0;
    end else if (sset) begin
      nq = mod - 1;
    end else if (gate) begin
      case (int'(mode))
        1: begin nq = int'(d); if (m_lcnt < lmax) m_lcnt = m_lcnt + 1; end
        2: begin m_sout = m_q / (mod / 2); nq = (m_q * 2) % mod + int'(sin); end
        3: begin m_sout = m_q % 2; nq = m_q / 2 + int'(sin) * (mod / 2); end
        4: nq = (m_q * 2) % mod + m_q / (mod / 2);
        5: nq = m_q / 2 + (m_q % 2) * (mod / 2);
        6: nq = mod - 1 - m_q;
        7: nq = (m_q + 1) % mod;
        default: nq = m_q;
      endcase
    end
    m_chg = (nq != m_q) ? 1 : 0;
    m_q = nq;
  endtask

  task automatic step(input bit r, input bit c, input bit s, input bit g,
                      input int md, input bit si, input int dv, input string tag);
    rst_n = r; sclr = c; sset = s; gate = g;
    mode = md[2:0]; sin = si; d = dv[W-1:0];
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".q"},    q,    m_q);
    chk({tag, ".sout"}, sout, m_sout);
    chk({tag, ".chg"},  chg,  m_chg);
    chk({tag, ".lcnt"}, lcnt, m_lcnt);
`ifdef UNIV_REG_PARITY_EN
    chk({tag, ".par"},  par,  parity(m_q));
`endif
  endtask

  initial begin
    // Reset overrides sset/load
    step(0, 0, 1, 1, 1, 0, 'hF, "rst0");
    step(0, 0, 1, 1, 1, 0, 'hF, "rst1");
    chk("rst_q", q, 0); chk("rst_lcnt", lcnt, 0); chk("rst_chg", chg, 0); chk("rst_sout", sout, 0);

    // Set/clear priority
    step(1, 1, 1, 1, 0, 0, 0, "sclr_sset");
    chk("sclr_wins_q", q, 0);
    step(1, 0, 1, 1, 0, 0, 0, "sset1");
    chk("sset_q", q, 'hF); chk("sset_chg", chg, 1);
    step(1, 0, 1, 1, 0, 0, 0, "sset2");
    chk("sset_again_chg", chg, 0);

    // Gate hold
    step(1, 0, 0, 1, 1, 0, 'hA, "loadA");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 6, 0, 0, "gate_off");
    chk("gate_hold_q", q, 'hA); chk("gate_hold_chg", chg, 0);
    step(1, 0, 0, 1, 6, 0, 0, "inv");
    chk("inv_q", q, 'h5); chk("inv_chg", chg, 1);

    // Shifts and rotates
    step(1, 0, 0, 1, 1, 0, 'h9, "load9");
    step(1, 0, 0, 1, 2, 0, 0, "shl");
    chk("shl_q", q, 'b0010); chk("shl_sout", sout, 1);
    step(1, 0, 0, 1, 3, 1, 0, "shr");
    chk("shr_q", q, 'b1001); chk("shr_sout", sout, 0);
    step(1, 0, 0, 1, 4, 0, 0, "rol");
    chk("rol_q", q, 'b0011);
    step(1, 0, 0, 1, 5, 0, 0, "ror");
    chk("ror_q", q, 'b1001);

    // Increment wrap
    step(1, 0, 0, 1, 1, 0, 'hE, "loadE");
    step(1, 0, 0, 1, 7, 0, 0, "inc1");
    chk("inc1_q", q, 'hF); chk("inc1_chg", chg, 1);
    step(1, 0, 0, 1, 7, 0, 0, "inc2");
    chk("inc2_q", q, 'h0); chk("inc2_chg", chg, 1);

    // lcnt saturation at 3 (CW=2)
    step(1, 1, 0, 1, 0, 0, 0, "clr_cnt");
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1, 1, 0, i + 3, "sat_load");
      chk("sat_lcnt", lcnt, (i < 3) ? i + 1 : 3);
    end
    step(1, 0, 0, 0, 1, 0, 5, "gated_load");
    chk("gated_load_lcnt", lcnt, 3);
    step(1, 1, 0, 1, 1, 0, 5, "sclr_cnt");
    chk("sclr_lcnt", lcnt, 0);
    step(1, 0, 1, 1, 1, 0, 5, "sset_blocks_load");
    chk("sset_block_lcnt", lcnt, 0);

    // Reset mid shift sequence
    step(1, 0, 0, 1, 2, 1, 0, "pre_rst_shl");
    step(0, 0, 0, 1, 2, 1, 0, "mid_rst");
    chk("mid_rst_q", q, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) != 0),
           $urandom_range(0, 7),
           $urandom_range(0, 1),
           $urandom_range(0, 15),
           "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/parameterized_univ_reg.md
Name: parameterized_univ_reg

Overview:
- Clocked, parameterised successor to the level-sensitive latch family. Holds a w-bit word and adds the following:
  - synchronous set/clear
  - a gate (enable)
  - an operation-mode selector: load, shift, rotate, invert, increment
  - change-detect and load-count status outputs
- Used as a general-purpose state/data register wherever the design previously used transparent latches. All updates occur on the rising clock edge.

Parameters:
- w, 4, data width in bits (w >= 2)
- CW, 8, width of load counter lcnt (CW >= 1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- sclr  input  1  synchronous clear of q
- sset  input  1  synchronous set of q (all ones)
- gate  input  1  operation enable; low = hold
- mode  input  3  operation select (see Behaviour)
- sin  input  1  serial input for shift modes
- d  input  w  parallel load data
- q  output  w  registered data word
- sout  output  1  registered bit shifted out by last shift operation
- chg  output  1  registered flag: q changed on the previous edge
- lcnt  output  CW  saturating count of load operations

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). No asynchronous paths.
- Reset (rst_n=0 at edge): q=0, sout=0, chg=0, lcnt=0. Reset overrides every other input.
- Priority at each edge (highest first): rst_n=0 > sclr=1 > sset=1 > gate=0 > mode operation.
- sclr=1: q<=0; lcnt<=0; sout unchanged. If sset=1 in the same cycle, sclr wins.
- sset=1 (sclr=0): q<={w{1}}; lcnt and sout unchanged.
- gate=0 (no sclr/sset): q, sout and lcnt hold. mode is ignored.
- gate=1, mode:
  - 0 hold: q unchanged.
  - 1 load: q<=d; lcnt<=lcnt+1, saturating at 2^CW-1 (no wrap).
  - 2 shift left: q<={q[w-2:0],sin}; sout<=q[w-1].
  - 3 shift right: q<={sin,q[w-1:1]}; sout<=q[0].
  - 4 rotate left: q<={q[w-2:0],q[w-1]}; sout unchanged.
  - 5 rotate right: q<={q[0],q[w-1:1]}; sout unchanged.
  - 6 invert: q<=~q.
  - 7 increment: q<=q+1 modulo 2^w; all-ones wraps to 0 with no carry output.
- chg: at each edge, chg<=(next q != current q), regardless of the cause (sclr, sset or mode). chg=0 when reset is applied.
- Latency:
  - q, sout and lcnt reflect inputs one edge after sampling.
  - chg is valid in the same cycle as the new q value, because both are computed from the same edge.
- lcnt counts only mode-1 operations that are actually executed. A load blocked by sclr, sset or gate=0 does not count.
- Reset asserted mid-operation (e.g. during a shift sequence) discards all state in one edge; there is no partial completion.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: UNIV_REG_PARITY_EN
- Defined:
  - Adds output port par (1 bit), the registered even parity of q, i.e. par=^q for the current q.
  - Reset value 0. Updated on every edge that updates q.
- Not defined: port par is absent. No parity logic is present. All other behaviour is identical.

Test Plan:
- Reset: drive rst_n=0 with sset=1, gate=1, mode=1, d=4'hF for 2 edges -> q=0, lcnt=0, chg=0, sout=0.
- Set/clear priority: sclr=1, sset=1 -> q=0, lcnt=0. Then sclr=0, sset=1 -> q=4'hF, chg=1. Repeat sset=1 -> chg=0.
- Gate hold: q=4'hA, gate=0, mode=6 for 3 edges -> q stays 4'hA, chg=0. Then gate=1 -> q=4'h5, chg=1.
- Shifts (w=4):
  - q=4'b1001, mode=2, sin=0 -> q=4'b0010, sout=1.
  - mode=3, sin=1 -> q=4'b1001, sout=0.
  - mode=4 -> q=4'b0011.
  - mode=5 -> q=4'b1001.
- Increment wrap: q=4'hE, mode=7 for 2 edges -> q=4'hF then 4'h0, chg=1 both edges.
- lcnt saturation (CW=2): 5 consecutive gated loads -> lcnt=1,2,3,3,3. A load with gate=0 does not count. sclr -> lcnt=0.
